// File: rtl/lru_miss_alloc_ctrl_if.sv
// ============================================================================
// Module      : lru_miss_alloc_ctrl_if
// Description : Request, LRU, tag-array and memory-side bundle of the miss/allocate controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lru_miss_alloc_ctrl_if #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 20
);
  logic                     req_valid;
  logic                     req_ready;
  logic [INDEX_W-1:0]       req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     hit;
  logic [1:0]               hit_way;

  logic                     lru_update_en;
  logic [INDEX_W-1:0]       lru_set_idx;
  logic [1:0]               lru_accessed_way;
  logic [INDEX_W-1:0]       lru_query_idx;
  logic [1:0]               lru_victim_way;
  logic                     victim_dirty;
  logic [TAG_W-1:0]         victim_tag;

  logic                     wb_req_valid;
  logic                     wb_req_ready;
  logic [INDEX_W+TAG_W-1:0] wb_req_addr;
  logic                     wb_done;
  logic                     fill_req_valid;
  logic                     fill_req_ready;
  logic [INDEX_W+TAG_W-1:0] fill_req_addr;
  logic                     fill_done;

  logic                     tag_wr_en;
  logic [INDEX_W-1:0]       tag_wr_idx;
  logic [1:0]               tag_wr_way;
  logic [TAG_W-1:0]         tag_wr_tag;

  logic                     resp_valid;
  logic [1:0]               resp_way;
  logic                     resp_miss;

  // Controller side
  modport master (
    input  req_valid, req_idx, req_tag, hit, hit_way,
    input  lru_victim_way, victim_dirty, victim_tag,
    input  wb_req_ready, wb_done, fill_req_ready, fill_done,
    output req_ready,
    output lru_update_en, lru_set_idx, lru_accessed_way, lru_query_idx,
    output wb_req_valid, wb_req_addr, fill_req_valid, fill_req_addr,
    output tag_wr_en, tag_wr_idx, tag_wr_way, tag_wr_tag,
    output resp_valid, resp_way, resp_miss
  );

  // Requester / LRU / tag array / memory side
  modport slave (
    output req_valid, req_idx, req_tag, hit, hit_way,
    output lru_victim_way, victim_dirty, victim_tag,
    output wb_req_ready, wb_done, fill_req_ready, fill_done,
    input  req_ready,
    input  lru_update_en, lru_set_idx, lru_accessed_way, lru_query_idx,
    input  wb_req_valid, wb_req_addr, fill_req_valid, fill_req_addr,
    input  tag_wr_en, tag_wr_idx, tag_wr_way, tag_wr_tag,
    input  resp_valid, resp_way, resp_miss
  );
endinterface

`default_nettype wire

// File: rtl/lru_miss_alloc_ctrl.sv
// ============================================================================
// Module      : lru_miss_alloc_ctrl
// Description : Hit/miss controller driving a 4-way true-LRU tracker, writeback, refill and tag write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lru_miss_alloc_ctrl #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  lru_miss_alloc_ctrl_if.master bus
);

  localparam int ADDR_W = INDEX_W + TAG_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MISS_Q    = 3'd1;
  localparam logic [2:0] S_VICTIM    = 3'd2;
  localparam logic [2:0] S_WB_REQ    = 3'd3;
  localparam logic [2:0] S_WB_WAIT   = 3'd4;
  localparam logic [2:0] S_FILL_REQ  = 3'd5;
  localparam logic [2:0] S_FILL_WAIT = 3'd6;
  localparam logic [2:0] S_COMMIT    = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [1:0]         vway_q, vway_d;
  logic               req_ready_q, req_ready_d;
  logic               upd_q, upd_d;
  logic [INDEX_W-1:0] upd_set_q, upd_set_d;
  logic [1:0]         upd_way_q, upd_way_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_way_q, resp_way_d;
  logic               resp_miss_q, resp_miss_d;
  logic               wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic               fill_valid_q, fill_valid_d;
  logic               tag_wr_q, tag_wr_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    vway_d       = vway_q;
    upd_d        = 1'b0;
    upd_set_d    = upd_set_q;
    upd_way_d    = upd_way_q;
    resp_valid_d = 1'b0;
    resp_way_d   = resp_way_q;
    resp_miss_d  = resp_miss_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    fill_valid_d = fill_valid_q;
    tag_wr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.hit) begin
            upd_d        = 1'b1;
            upd_set_d    = bus.req_idx;
            upd_way_d    = bus.hit_way;
            resp_valid_d = 1'b1;
            resp_way_d   = bus.hit_way;
            resp_miss_d  = 1'b0;
          end else begin
            idx_d   = bus.req_idx;
            tag_d   = bus.req_tag;
            state_d = S_MISS_Q;
          end
        end
      end
      // The tracker's victim register needs one edge after lru_query_idx settles.
      S_MISS_Q: state_d = S_VICTIM;
      S_VICTIM: begin
        vway_d = bus.lru_victim_way;
        if (bus.victim_dirty) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = {bus.victim_tag, idx_q};
          state_d    = S_WB_REQ;
        end else begin
          fill_valid_d = 1'b1;
          state_d      = S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        if (bus.wb_req_ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_WB_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (bus.wb_done) begin
          fill_valid_d = 1'b1;
          state_d      = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        if (bus.fill_req_ready) begin
          fill_valid_d = 1'b0;
          state_d      = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (bus.fill_done) begin
          tag_wr_d     = 1'b1;
          upd_d        = 1'b1;
          upd_set_d    = idx_q;
          upd_way_d    = vway_q;
          resp_valid_d = 1'b1;
          resp_way_d   = vway_q;
          resp_miss_d  = 1'b1;
          state_d      = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      vway_q       <= '0;
      req_ready_q  <= 1'b1;
      upd_q        <= 1'b0;
      upd_set_q    <= '0;
      upd_way_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_miss_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      fill_valid_q <= 1'b0;
      tag_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      vway_q       <= vway_d;
      req_ready_q  <= req_ready_d;
      upd_q        <= upd_d;
      upd_set_q    <= upd_set_d;
      upd_way_q    <= upd_way_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_miss_q  <= resp_miss_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      fill_valid_q <= fill_valid_d;
      tag_wr_q     <= tag_wr_d;
    end
  end

  // Latched miss registers double as the stable address/tag-write fields.
  assign bus.req_ready        = req_ready_q;
  assign bus.lru_update_en    = upd_q;
  assign bus.lru_set_idx      = upd_set_q;
  assign bus.lru_accessed_way = upd_way_q;
  assign bus.lru_query_idx    = idx_q;
  assign bus.wb_req_valid     = wb_valid_q;
  assign bus.wb_req_addr      = wb_addr_q;
  assign bus.fill_req_valid   = fill_valid_q;
  assign bus.fill_req_addr    = {tag_q, idx_q};
  assign bus.tag_wr_en        = tag_wr_q;
  assign bus.tag_wr_idx       = idx_q;
  assign bus.tag_wr_way       = vway_q;
  assign bus.tag_wr_tag       = tag_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_way         = resp_way_q;
  assign bus.resp_miss        = resp_miss_q;

endmodule

`default_nettype wire

// File: tb/tb_lru_miss_alloc_ctrl.sv
// ============================================================================
// Module      : tb_lru_miss_alloc_ctrl
// Description : Bench with LRU/tag/memory environment model, vector table and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lru_miss_alloc_ctrl;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 20;
  localparam int SETS    = 1 << INDEX_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lru_miss_alloc_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();
  lru_miss_alloc_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));

  // Environment: true-LRU ages (0 = MRU, 3 = LRU), tag and dirty arrays.
  int               rank  [SETS][4];
  logic             dirty_a [SETS][4];
  logic [TAG_W-1:0] tag_a [SETS][4];
  logic               env_init = 1'b0, pre_en = 1'b0, pre_dirty = 1'b0;
  logic [INDEX_W-1:0] pre_idx = '0;
  logic [1:0]         pre_way = '0;
  logic [TAG_W-1:0]   pre_tag = '0;

  function automatic logic [1:0] lru_of(input logic [INDEX_W-1:0] s);
    for (int w = 0; w < 4; w++) if (rank[s][w] == 3) return 2'(w);
    return 2'd0;
  endfunction

  function automatic void touch(input int s, input int w);
    int old;
    old = rank[s][w];
    for (int k = 0; k < 4; k++) if (rank[s][k] < old) rank[s][k] = rank[s][k] + 1;
    rank[s][w] = 0;
  endfunction

  always @(posedge clk) begin
    if (env_init) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < 4; w++) begin
          rank[s][w]    = w;
          dirty_a[s][w] = 1'b0;
          tag_a[s][w]   = TAG_W'(s * 4 + w + 256);
        end
    end else begin
      if (pre_en) begin
        dirty_a[pre_idx][pre_way] = pre_dirty;
        tag_a[pre_idx][pre_way]   = pre_tag;
      end
      if (bus.lru_update_en) touch(int'(bus.lru_set_idx), int'(bus.lru_accessed_way));
      if (bus.tag_wr_en) begin
        tag_a[bus.tag_wr_idx][bus.tag_wr_way]   = bus.tag_wr_tag;
        dirty_a[bus.tag_wr_idx][bus.tag_wr_way] = 1'b0;
      end
    end
    bus.lru_victim_way <= lru_of(bus.lru_query_idx);
  end

  assign bus.victim_dirty = dirty_a[bus.lru_query_idx][bus.lru_victim_way];
  assign bus.victim_tag   = tag_a[bus.lru_query_idx][bus.lru_victim_way];

  int wb_hs = 0, f_hs = 0;
  always @(posedge clk) begin
    if (bus.wb_req_valid && bus.wb_req_ready) wb_hs <= wb_hs + 1;
    if (bus.fill_req_valid && bus.fill_req_ready) f_hs <= f_hs + 1;
  end

  // Expected outputs for the next checked cycle
  int n_chk = 0, n_err = 0;
  logic               exp_ready = 1'b1, exp_upd = 1'b0, exp_resp = 1'b0, exp_miss = 1'b0;
  logic               exp_tw = 1'b0, exp_wbv = 1'b0, exp_fv = 1'b0;
  logic [INDEX_W-1:0] exp_set = '0, exp_tw_idx = '0;
  logic [1:0]         exp_uway = '0, exp_rway = '0, exp_tw_way = '0;
  logic [TAG_W-1:0]   exp_tw_tag = '0;
  logic [INDEX_W+TAG_W-1:0] exp_wb_addr = '0, exp_f_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("req_ready", bus.req_ready, exp_ready);
    chk("lru_update_en", bus.lru_update_en, exp_upd);
    if (exp_upd) begin
      chk("lru_set_idx", bus.lru_set_idx, exp_set);
      chk("lru_accessed_way", bus.lru_accessed_way, exp_uway);
    end
    chk("resp_valid", bus.resp_valid, exp_resp);
    if (exp_resp) begin
      chk("resp_way", bus.resp_way, exp_rway);
      chk("resp_miss", bus.resp_miss, exp_miss);
    end
    chk("tag_wr_en", bus.tag_wr_en, exp_tw);
    if (exp_tw) begin
      chk("tag_wr_idx", bus.tag_wr_idx, exp_tw_idx);
      chk("tag_wr_way", bus.tag_wr_way, exp_tw_way);
      chk("tag_wr_tag", bus.tag_wr_tag, exp_tw_tag);
    end
    chk("wb_req_valid", bus.wb_req_valid, exp_wbv);
    if (exp_wbv) chk("wb_req_addr", bus.wb_req_addr, exp_wb_addr);
    chk("fill_req_valid", bus.fill_req_valid, exp_fv);
    if (exp_fv) chk("fill_req_addr", bus.fill_req_addr, exp_f_addr);
  endtask

  task automatic step();
    @(negedge clk);
    check_outs();
    exp_upd = 1'b0; exp_resp = 1'b0; exp_tw = 1'b0;
  endtask

  task automatic quiet();
    bus.req_valid = 1'b0; bus.hit = 1'b0; bus.req_idx = '0; bus.req_tag = '0; bus.hit_way = '0;
    bus.wb_req_ready = 1'b0; bus.wb_done = 1'b0; bus.fill_req_ready = 1'b0; bus.fill_done = 1'b0;
  endtask

  task automatic do_hit(input logic [INDEX_W-1:0] idx, input logic [1:0] way);
    bus.req_valid = 1'b1; bus.hit = 1'b1; bus.req_idx = idx; bus.hit_way = way;
    bus.req_tag = TAG_W'($urandom);
    exp_upd = 1'b1; exp_set = idx; exp_uway = way;
    exp_resp = 1'b1; exp_rway = way; exp_miss = 1'b0;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_miss(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input int wb_st, input int wb_lt, input int f_st, input int f_lt,
                         input bit abort);
    logic [1:0] v; logic d; logic [TAG_W-1:0] vt; int wb0, f0;
    bus.req_valid = 1'b1; bus.hit = 1'b0; bus.req_idx = idx; bus.req_tag = tag;
    bus.hit_way = 2'($urandom);
    exp_ready = 1'b0;
    step();
    wb0 = wb_hs; f0 = f_hs;
    // Requests while busy must be ignored
    bus.req_valid = 1'($urandom); bus.hit = 1'($urandom); bus.req_idx = INDEX_W'($urandom);
    bus.wb_req_ready = 1'($urandom); bus.fill_req_ready = 1'($urandom);
    bus.wb_done = 1'($urandom); bus.fill_done = 1'($urandom);
    step();
    v = lru_of(idx); d = dirty_a[idx][v]; vt = tag_a[idx][v];
    if (d) begin exp_wbv = 1'b1; exp_wb_addr = {vt, idx}; end
    else   begin exp_fv = 1'b1; exp_f_addr = {tag, idx}; end
    step();
    bus.req_valid = 1'b0; bus.hit = 1'b0;
    if (d) begin
      for (int i = 0; i < wb_st; i++) begin
        bus.wb_req_ready = 1'b0; bus.wb_done = 1'($urandom);
        bus.fill_done = 1'($urandom); bus.fill_req_ready = 1'($urandom);
        step();
      end
      bus.wb_req_ready = 1'b1; bus.wb_done = 1'b0; bus.fill_done = 1'b0; exp_wbv = 1'b0;
      step();
      for (int i = 0; i < wb_lt; i++) begin
        bus.wb_req_ready = 1'($urandom); bus.wb_done = 1'b0; bus.fill_done = 1'($urandom);
        step();
      end
      bus.wb_done = 1'b1; bus.fill_done = 1'b0; bus.wb_req_ready = 1'b0; bus.fill_req_ready = 1'b0;
      exp_fv = 1'b1; exp_f_addr = {tag, idx};
      step();
      bus.wb_done = 1'b0;
    end
    chk("wb_handshakes", 64'(wb_hs - wb0), d ? 64'd1 : 64'd0);
    for (int i = 0; i < f_st; i++) begin
      bus.fill_req_ready = 1'b0; bus.fill_done = 1'($urandom);
      bus.wb_done = 1'($urandom); bus.wb_req_ready = 1'($urandom);
      step();
    end
    bus.fill_req_ready = 1'b1; bus.fill_done = 1'b0; bus.wb_done = 1'b0; exp_fv = 1'b0;
    step();
    for (int i = 0; i < f_lt; i++) begin
      bus.fill_req_ready = 1'($urandom); bus.fill_done = 1'b0; bus.wb_done = 1'($urandom);
      step();
    end
    if (abort) begin
      reset_n = 1'b0;
      #1;
      exp_ready = 1'b1;
      check_outs();
      bus.fill_done = 1'b1;
      step();
      reset_n = 1'b1;
      step();
      bus.fill_done = 1'b0;
      step();
    end else begin
      bus.fill_done = 1'b1; bus.wb_done = 1'b0;
      exp_upd = 1'b1; exp_set = idx; exp_uway = v;
      exp_resp = 1'b1; exp_rway = v; exp_miss = 1'b1;
      exp_tw = 1'b1; exp_tw_idx = idx; exp_tw_way = v; exp_tw_tag = tag;
      step();
      bus.fill_done = 1'b0;
      exp_ready = 1'b1;
      step();
    end
    chk("fill_handshakes", 64'(f_hs - f0), 64'd1);
    quiet();
  endtask

  typedef struct {
    logic rv; logic hit; logic [INDEX_W-1:0] idx; logic [1:0] way;
    logic e_upd; logic [INDEX_W-1:0] e_set; logic [1:0] e_way;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 6'd5,  2'd2, 1'b1, 6'd5,  2'd2};
    tbl[1] = '{1'b0, 1'b1, 6'd5,  2'd2, 1'b0, 6'd0,  2'd0};
    tbl[2] = '{1'b1, 1'b1, 6'd12, 2'd0, 1'b1, 6'd12, 2'd0};
    tbl[3] = '{1'b1, 1'b1, 6'd12, 2'd1, 1'b1, 6'd12, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 6'd63, 2'd3, 1'b1, 6'd63, 2'd3};
    tbl[5] = '{1'b0, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd0};
    tbl[6] = '{1'b1, 1'b1, 6'd0,  2'd1, 1'b1, 6'd0,  2'd1};
    tbl[7] = '{1'b0, 1'b1, 6'd40, 2'd3, 1'b0, 6'd0,  2'd0};

    quiet();
    env_init = 1'b1;
    exp_ready = 1'b1;
    step();
    step();
    env_init = 1'b0;
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      bus.req_valid = tbl[i].rv; bus.hit = tbl[i].hit;
      bus.req_idx = tbl[i].idx; bus.hit_way = tbl[i].way;
      exp_upd = tbl[i].e_upd; exp_set = tbl[i].e_set; exp_uway = tbl[i].e_way;
      exp_resp = tbl[i].e_upd; exp_rway = tbl[i].e_way; exp_miss = 1'b0;
      step();
    end
    quiet();
    step();

    // Clean miss: set 3 still in reset age order, way 3 oldest
    do_miss(6'd3, 20'hABCDE, 0, 0, 1, 2, 1'b0);

    // Dirty victim in set 7 with a stalled writeback
    pre_en = 1'b1; pre_idx = 6'd7; pre_way = 2'd3; pre_dirty = 1'b1; pre_tag = 20'h12345;
    step();
    pre_en = 1'b0;
    do_miss(6'd7, 20'h55555, 4, 2, 0, 1, 1'b0);

    // Hit on the LRU way immediately before a miss to the same set
    do_hit(6'd9, 2'd3);
    do_miss(6'd9, 20'h0F0F0, 0, 0, 0, 0, 1'b0);

    // Reset while waiting for refill
    do_miss(6'd20, 20'hBEEF0, 0, 0, 1, 1, 1'b1);
    do_hit(6'd20, 2'd1);
    quiet();
    step();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0, 1: do_hit(INDEX_W'($urandom), 2'($urandom));
        2: do_miss(INDEX_W'($urandom), TAG_W'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        default: begin
          pre_en = 1'b1; pre_idx = INDEX_W'($urandom); pre_way = 2'($urandom);
          pre_dirty = 1'($urandom); pre_tag = TAG_W'($urandom);
          bus.wb_done = 1'($urandom); bus.fill_done = 1'($urandom);
          bus.wb_req_ready = 1'($urandom); bus.fill_req_ready = 1'($urandom);
          step();
          pre_en = 1'b0;
        end
      endcase
      quiet();
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
